// File: rtl/inv_bank_sync_if.sv
// Gate-bank bus: sampled inputs, registered gate outputs and the event stream.
interface inv_bank_sync_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             ev_valid;
  logic             ev_ready;
  logic [WIDTH-1:0] ev_value;
  logic [WIDTH-1:0] ev_mask;
  logic [31:0]      ev_time;
  logic             ev_overflow;

  modport master (
    output in, ev_ready,
    input  out, ev_valid, ev_value, ev_mask, ev_time, ev_overflow
  );

  modport slave (
    input  in, ev_ready,
    output out, ev_valid, ev_value, ev_mask, ev_time, ev_overflow
  );
endinterface

// File: rtl/inv_bank_sync.sv
// Bank of inertially-filtered inverter/buffer gates; every output change is
// logged as a timestamped event in a small FIFO with a sticky overflow flag.
module inv_bank_sync #(
  parameter int unsigned      WIDTH      = 4,
  parameter int unsigned      MODE       = 0,
  parameter int unsigned      GATE_DELAY = 2,
  parameter logic [WIDTH-1:0] INIT_V     = '0,
  parameter int unsigned      DEPTH      = 4
) (
  input logic           clk,
  input logic           rst_n,
  inv_bank_sync_if.slave bus
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW       = 2 * WIDTH + 32;
  localparam logic [3:0]  GD       = 4'(GATE_DELAY);
  localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_nxt;
  logic [WIDTH-1:0] chg;
  logic [3:0]       dcnt_q   [WIDTH];
  logic [3:0]       dcnt_nxt [WIDTH];
  logic [31:0]      tstamp_q;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wp_q;
  logic [AW-1:0]    rp_q;
  logic [AW:0]      occ_q;
  logic             ovf_q;
  logic             vld;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr_en;

  // Gate stage: a channel commits only after GATE_DELAY+1 consecutive
  // differing samples; any agreeing sample cancels and restarts the count.
  always_comb begin
    tgt     = (MODE == 0) ? ~bus.in : bus.in;
    out_nxt = out_q;
    for (int i = 0; i < WIDTH; i++) begin
      dcnt_nxt[i] = '0;
      if (tgt[i] != out_q[i]) begin
        if (dcnt_q[i] == GD) out_nxt[i] = tgt[i];
        else                 dcnt_nxt[i] = dcnt_q[i] + 4'd1;
      end
    end
  end

  assign chg   = out_nxt ^ out_q;
  assign push  = |chg;
  assign vld   = (occ_q != '0);
  assign full  = (occ_q == FULL_OCC);
  assign pop   = vld && bus.ev_ready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= INIT_V;
      tstamp_q <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < WIDTH; i++) dcnt_q[i] <= '0;
    end else begin
      out_q    <= out_nxt;
      dcnt_q   <= dcnt_nxt;
      tstamp_q <= tstamp_q + 32'd1;
      if (wr_en) wp_q <= wp_q + AW'(1);
      if (pop)   rp_q <= rp_q + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   occ_q <= occ_q + (AW + 1)'(1);
        2'b01:   occ_q <= occ_q - (AW + 1)'(1);
        default: occ_q <= occ_q;
      endcase
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  // Event stage: storage carries no reset, occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp_q] <= {out_nxt, chg, tstamp_q};
  end

  assign bus.out         = out_q;
  assign bus.ev_valid    = vld;
  assign bus.ev_overflow = ovf_q;
  assign {bus.ev_value, bus.ev_mask, bus.ev_time} = mem[rp_q];

endmodule

// File: tb/tb_inv_bank_sync.sv
// Bench for inv_bank_sync: two instances (delay 2 and delay 4) against a
// sample-history/queue model plus directed literal expectations.
module tb_inv_bank_sync;

  localparam int W   = 4;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic rsta_n;
  logic rstb_n;
  int   ntests = 0;
  int   nfail  = 0;

  inv_bank_sync_if #(.WIDTH(W)) ifa ();
  inv_bank_sync_if #(.WIDTH(W)) ifb ();

  inv_bank_sync #(.WIDTH(W), .MODE(0), .GATE_DELAY(2), .INIT_V(4'h0), .DEPTH(DEP))
    dut_a (.clk(clk), .rst_n(rsta_n), .bus(ifa.slave));
  inv_bank_sync #(.WIDTH(W), .MODE(0), .GATE_DELAY(4), .INIT_V(4'hA), .DEPTH(DEP))
    dut_b (.clk(clk), .rst_n(rstb_n), .bus(ifb.slave));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] v;
    logic [W-1:0] m;
    logic [31:0]  t;
  } ev_t;

  ev_t          evq  [2][$];
  logic [W-1:0] m_out [2];
  logic         m_ovf [2];
  logic [31:0]  m_time[2];
  logic [W-1:0] hist [2][16];
  int           nh   [2];

  function automatic int dly_of(int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic logic [W-1:0] init_of(int i);
    return (i == 0) ? 4'h0 : 4'hA;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mreset(int i);
    m_out[i]  = init_of(i);
    m_ovf[i]  = 1'b0;
    m_time[i] = 32'd0;
    nh[i]     = 0;
    evq[i].delete();
  endtask

  // A bit flips once its last D+1 targets (all since reset) disagree with it.
  task automatic mstep(int i, logic [W-1:0] inv, logic rdy);
    logic [W-1:0] tv;
    logic [W-1:0] newo;
    bit           flip;
    bit           full;
    bit           popn;
    ev_t          e;
    tv = ~inv;
    for (int j = 15; j > 0; j--) hist[i][j] = hist[i][j-1];
    hist[i][0] = tv;
    if (nh[i] < 16) nh[i]++;
    newo = m_out[i];
    for (int b = 0; b < W; b++) begin
      flip = (nh[i] >= dly_of(i) + 1);
      for (int j = 0; j <= dly_of(i); j++)
        if (hist[i][j][b] == m_out[i][b]) flip = 1'b0;
      if (flip) newo[b] = tv[b];
    end
    full = (evq[i].size() == DEP);
    popn = (evq[i].size() > 0) && rdy;
    if (popn) void'(evq[i].pop_front());
    if (newo != m_out[i]) begin
      if (!full || popn) begin
        e.v = newo;
        e.m = newo ^ m_out[i];
        e.t = m_time[i];
        evq[i].push_back(e);
      end else begin
        m_ovf[i] = 1'b1;
      end
    end
    m_out[i]  = newo;
    m_time[i] = m_time[i] + 32'd1;
  endtask

  always @(posedge clk or negedge rsta_n)
    if (!rsta_n) mreset(0); else mstep(0, ifa.in, ifa.ev_ready);

  always @(posedge clk or negedge rstb_n)
    if (!rstb_n) mreset(1); else mstep(1, ifb.in, ifb.ev_ready);

  task automatic cmp(int i, logic [W-1:0] o, logic vld, logic ov,
                     logic [W-1:0] val, logic [W-1:0] msk, logic [31:0] tm);
    string p;
    p = (i == 0) ? "a" : "b";
    chk({p, ".out"},      32'(o),   32'(m_out[i]));
    chk({p, ".ev_valid"}, 32'(vld), 32'(evq[i].size() > 0));
    chk({p, ".ev_ovf"},   32'(ov),  32'(m_ovf[i]));
    if (evq[i].size() > 0) begin
      chk({p, ".ev_value"}, 32'(val), 32'(evq[i][0].v));
      chk({p, ".ev_mask"},  32'(msk), 32'(evq[i][0].m));
      chk({p, ".ev_time"},  tm,       evq[i][0].t);
    end
  endtask

  always @(negedge clk) begin
    cmp(0, ifa.out, ifa.ev_valid, ifa.ev_overflow, ifa.ev_value, ifa.ev_mask, ifa.ev_time);
    cmp(1, ifb.out, ifb.ev_valid, ifb.ev_overflow, ifb.ev_value, ifb.ev_mask, ifb.ev_time);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] seq  [5] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE};
  logic [W-1:0] expv [4] = '{4'hE, 4'hC, 4'h8, 4'h0};
  logic [W-1:0] expm [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

  initial begin
    rsta_n = 1'b0;
    rstb_n = 1'b0;
    ifa.in = 4'h0;
    ifb.in = 4'h0;
    ifa.ev_ready = 1'b0;
    ifb.ev_ready = 1'b1;
    tick();
    tick();
    chk("rst_a_out",   32'(ifa.out), 32'h0);
    chk("rst_b_out",   32'(ifb.out), 32'hA);
    chk("rst_a_valid", 32'(ifa.ev_valid), 32'h0);
    chk("rst_b_valid", 32'(ifb.ev_valid), 32'h0);
    chk("rst_a_ovf",   32'(ifa.ev_overflow), 32'h0);
    rsta_n = 1'b1;
    rstb_n = 1'b1;

    // first transition out of reset
    tick();
    tick();
    chk("first_out_e2", 32'(ifa.out), 32'h0);
    tick();
    chk("first_out_e3", 32'(ifa.out), 32'hF);
    chk("first_valid",  32'(ifa.ev_valid), 32'h1);
    chk("first_value",  32'(ifa.ev_value), 32'hF);
    chk("first_mask",   32'(ifa.ev_mask),  32'hF);
    chk("first_time",   ifa.ev_time, 32'd2);
    ifa.ev_ready = 1'b1;
    tick();
    ifa.ev_ready = 1'b0;
    chk("first_popped", 32'(ifa.ev_valid), 32'h0);

    // inertial filtering on channel 0
    ifa.ev_ready = 1'b1;
    ifa.in = 4'h1;
    tick();
    tick();
    ifa.in = 4'h0;
    tick();
    chk("pulse2_out_a", 32'(ifa.out), 32'hF);
    tick();
    tick();
    chk("pulse2_out_b", 32'(ifa.out), 32'hF);
    chk("pulse2_noev",  32'(ifa.ev_valid), 32'h0);
    ifa.in = 4'h1;
    tick();
    tick();
    tick();
    chk("pulse3_on", 32'(ifa.out), 32'hE);
    ifa.in = 4'h0;
    tick();
    tick();
    chk("pulse3_hold", 32'(ifa.out), 32'hE);
    tick();
    chk("pulse3_back", 32'(ifa.out), 32'hF);
    tick();
    tick();
    chk("pulse3_drained", 32'(ifa.ev_valid), 32'h0);

    // two channels changing on the same edge
    ifa.ev_ready = 1'b0;
    ifa.in = 4'hA;
    repeat (3) tick();
    chk("merge_out",   32'(ifa.out), 32'h5);
    chk("merge_valid", 32'(ifa.ev_valid), 32'h1);
    chk("merge_mask",  32'(ifa.ev_mask),  32'hA);
    chk("merge_value", 32'(ifa.ev_value), 32'h5);
    ifa.ev_ready = 1'b1;
    ifa.in = 4'h0;
    repeat (3) tick();
    chk("merge_back", 32'(ifa.out), 32'hF);
    tick();
    tick();
    chk("merge_drained", 32'(ifa.ev_valid), 32'h0);

    // overflow: five changes into a four-entry FIFO
    ifa.ev_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ifa.in = seq[k];
      repeat (3) tick();
    end
    chk("ovf_set",   32'(ifa.ev_overflow), 32'h1);
    chk("ovf_out",   32'(ifa.out), 32'h1);
    for (int k = 0; k < 4; k++) begin
      chk("ovf_order_valid", 32'(ifa.ev_valid), 32'h1);
      chk("ovf_order_value", 32'(ifa.ev_value), 32'(expv[k]));
      chk("ovf_order_mask",  32'(ifa.ev_mask),  32'(expm[k]));
      ifa.ev_ready = 1'b1;
      tick();
      ifa.ev_ready = 1'b0;
    end
    chk("ovf_empty",  32'(ifa.ev_valid), 32'h0);
    chk("ovf_sticky", 32'(ifa.ev_overflow), 32'h1);

    // full FIFO with simultaneous push and pop
    ifa.in = 4'h0;
    rsta_n = 1'b0;
    tick();
    chk("rst2_ovf_clear", 32'(ifa.ev_overflow), 32'h0);
    rsta_n = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      ifa.in = seq[k];
      repeat (3) tick();
    end
    ifa.in = 4'hF;
    tick();
    tick();
    ifa.ev_ready = 1'b1;
    tick();
    ifa.ev_ready = 1'b0;
    chk("pp_ovf",   32'(ifa.ev_overflow), 32'h0);
    chk("pp_out",   32'(ifa.out), 32'h0);
    chk("pp_head",  32'(ifa.ev_value), 32'hE);
    for (int k = 0; k < 4; k++) begin
      chk("pp_drain_valid", 32'(ifa.ev_valid), 32'h1);
      chk("pp_drain_value", 32'(ifa.ev_value), 32'(expv[k]));
      ifa.ev_ready = 1'b1;
      tick();
      ifa.ev_ready = 1'b0;
    end
    chk("pp_empty", 32'(ifa.ev_valid), 32'h0);

    // reset pulse into a pending delay-4 change
    ifb.ev_ready = 1'b0;
    ifb.in = 4'hF;
    tick();
    tick();
    rstb_n = 1'b0;
    tick();
    chk("b_rst_out",   32'(ifb.out), 32'hA);
    chk("b_rst_valid", 32'(ifb.ev_valid), 32'h0);
    rstb_n = 1'b1;
    repeat (4) tick();
    chk("b_hold_out",   32'(ifb.out), 32'hA);
    chk("b_hold_valid", 32'(ifb.ev_valid), 32'h0);
    tick();
    chk("b_chg_out",  32'(ifb.out), 32'h0);
    chk("b_chg_vld",  32'(ifb.ev_valid), 32'h1);
    chk("b_chg_mask", 32'(ifb.ev_mask), 32'hA);
    chk("b_chg_time", ifb.ev_time, 32'd4);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
